// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latched request, word geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled word storage; read data registered on the enabled edge, no reset.
// Writes return the pre-write word on rdata; the responder masks it.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 64,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle memory responder: one request at a time, response max(LATENCY,1) edges after accept
// (LATENCY=0 responds on the accept edge); response held until rsp_ready, req_ready only in IDLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, in_req, acc_req;
    logic        accept, access, acc_oor, arr_en;
    logic        rsp_err_q, rsp_rd_q;
    logic [31:0] arr_rdata;
    logic        unused_addr_bits;

    assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // With LATENCY=0 the access happens on the accept edge, before req_q holds the request.
    assign acc_req = (state_q == IDLE) ? in_req : req_q;
    assign acc_oor = {2'b00, acc_req.addr[31:2]} >= DEPTH_LIM;
    assign arr_en  = access && !acc_oor;
    assign unused_addr_bits = ^acc_req.addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = LAT_INIT;
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= in_req;
            end
            if (access) begin
                rsp_err_q <= acc_oor;
                rsp_rd_q  <= !acc_oor && !acc_req.we;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (acc_req.we),
        .be    (acc_req.be),
        .idx   (acc_req.addr[2 +: IDX_W]),
        .wdata (acc_req.wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = reset && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rd_q ? arr_rdata : 32'h0;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the load/store interface the memory stage initiates. Accepts one word request (read or byte-enabled write) over a valid/ready handshake, waits a fixed number of cycles to model memory latency, then returns a response held until the requester takes it. It is the slave-side counterpart the memory stage issues `ALUResultM`/`WriteDataM`-style accesses to once data memory stops being single-cycle.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: wait cycles between request accept and response; 0–15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  requester presents a request.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address; bits [1:0] ignored, word index = `req_addr[31:2]`.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables for writes; lane i = bits [8i+7:8i].
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  requester takes response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  request word index ≥ `DEPTH_WORDS`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. If `req_valid` is high at an edge: latch we/addr/wdata/be, load `cnt`=LATENCY, go to WAIT. If LATENCY=0, go directly to RESP instead.
- WAIT: `req_ready`=0. Decrement `cnt` each edge. On the edge where `cnt`=1, perform the access and go to RESP.
- Access, performed exactly once per request on the entry edge into RESP:
  - Out of range: no array change; `rsp_err`=1, `rsp_rdata`=0.
  - Write: update only the enabled bytes; `rsp_rdata`=0, `rsp_err`=0. `be`=0 is a legal no-op write.
  - Read: `rsp_rdata`=word, `rsp_err`=0.
- RESP: `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable. On an edge with `rsp_ready`=1, go to IDLE and clear `rsp_valid`.
- Only one request is outstanding. Requests presented outside IDLE are not accepted and need not be held by the responder.
- Array contents are not reset and read as X until written.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `cnt`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=1 once reset is deasserted (held 0 while reset is low).
- Reset mid-transaction: the request is dropped. A write not yet performed never reaches the array; a write already performed remains.
- Latency: request accepted at edge N, so `rsp_valid` is high from edge N+max(LATENCY,1) onward. LATENCY=0 and LATENCY=1 are both one cycle.
- Throughput with `rsp_ready` tied high: one request per max(LATENCY,1)+1 cycles.
- `rsp_ready` high while `rsp_valid`=0 is ignored.
- `req_ready` is decoded from state only, with no combinational path from `req_valid` or `rsp_ready`.
- A read issued after a write to the same word sees the written data, because accesses are strictly sequential.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum {IDLE, WAIT, RESP}.
  - `dmem_req_t` struct {we, addr, wdata, be}.
  - Constant `WORD_BYTES`=4.
- Sub-module `dmem_array`:
  - synchronous byte-enabled single-port storage (`clk`, `en`, `we`, `be`, `idx`, `wdata` → `rdata`).
  - registered read data, loaded on the access edge.
- `dmem_responder`: FSM, latency counter, request latch, range check, and response registers.

## Test plan
- Reset mid-WAIT: LATENCY=4, write 0xDEADBEEF to 0x10, assert reset 2 cycles after accept, then read 0x10 → 0xDEADBEEF is never returned; after reset, `rsp_valid`=0 and `req_ready`=1.
- Write then read: LATENCY=2, write 0x12345678 to 0x20 with be=4'hF, then read 0x20 → `rsp_rdata`=0x12345678, `rsp_err`=0; each `rsp_valid` rises 2 cycles after accept.
- Byte enables: after the word above, write 0xAABBCCDD with be=4'b0101 → read returns 0x12BB56DD.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0, a new `req_valid` is not accepted.
- Out of range: DEPTH_WORDS=64, write to 0x100 → `rsp_err`=1, `rsp_rdata`=0, and a later read of 0x0 is unchanged.
- LATENCY=0: `rsp_valid` is high in the cycle after accept. With `rsp_ready`=1, four consecutive reads complete in 8 cycles.
